// File: rtl/sync_updown_counter_if.sv
// Control and status bundle for sync_updown_counter.
// The master side drives the controls and observes the count; the counter is the slave.
interface sync_updown_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  q, tc, wrap
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output q, tc, wrap
  );

endinterface

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with prescaler, load, clear, tc and wrap.
// Define SYNC_COUNTER_SAT_EN to saturate at the range limits instead of wrapping.
module sync_updown_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MOD_VAL  = 16,
  parameter int     PRESCALE = 1
) (
  input logic                clk,
  input logic                rst,
  sync_updown_counter_if.slave bus
);

  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD_VAL);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD_VAL - 1);
  localparam logic [PW-1:0]    PS_TOP  = PW'(PRESCALE - 1);

  // Reject illegal configurations at elaboration rather than building a broken counter.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_updown_counter: WIDTH must be in 1..32");
  end
  if (MOD_VAL < 2 || MOD_VAL > (longint'(1) << WIDTH)) begin : g_bad_mod
    $error("sync_updown_counter: MOD_VAL must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
    $error("sync_updown_counter: PRESCALE must be in 1..65536");
  end

  logic [WIDTH-1:0] q_r,  q_nxt;
  logic [PW-1:0]    ps_r, ps_nxt;
  logic             wrap_r, wrap_nxt;

  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] step_q;
  logic             step_wrap;

  // Compare at WIDTH+1 bits so MOD_VAL = 2**WIDTH never clamps.
  assign load_q = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : TOP;

  // Value and boundary flag a step would produce from the current count.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    step_q    = q_r;
    step_wrap = 1'b0;
    if (bus.up_dn) begin
      if (q_r == TOP) begin
        step_wrap = 1'b1;
`ifdef SYNC_COUNTER_SAT_EN
        step_q    = q_r;
`else
        step_q    = '0;
`endif
      end else begin
        step_q = q_r + WIDTH'(1);
      end
    end else begin
      if (q_r == '0) begin
        step_wrap = 1'b1;
`ifdef SYNC_COUNTER_SAT_EN
        step_q    = q_r;
`else
        step_q    = TOP;
`endif
      end else begin
        step_q = q_r - WIDTH'(1);
      end
    end
  end

  // Priority: clear, then load, then an enabled prescaler tick.
  always_comb begin
    q_nxt    = q_r;
    ps_nxt   = ps_r;
    wrap_nxt = 1'b0;
    if (bus.clear) begin
      q_nxt  = '0;
      ps_nxt = '0;
    end else if (bus.load) begin
      q_nxt  = load_q;
      ps_nxt = '0;
    end else if (bus.en) begin
      if (ps_r == PS_TOP) begin
        ps_nxt   = '0;
        q_nxt    = step_q;
        wrap_nxt = step_wrap;
      end else begin
        ps_nxt = ps_r + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= '0;
      ps_r   <= '0;
      wrap_r <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      q_r    <= q_nxt;
      ps_r   <= ps_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.tc   = (bus.up_dn && (q_r == TOP)) || (!bus.up_dn && (q_r == '0));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench for sync_updown_counter: three configurations driven in parallel
// and compared every cycle against an arithmetic reference model.
module tb_sync_updown_counter;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, clear, load;
  logic [3:0] load_val;

  always #5 clk = ~clk;

  sync_updown_counter_if #(.WIDTH(4)) ifa ();
  sync_updown_counter_if #(.WIDTH(4)) ifb ();
  sync_updown_counter_if #(.WIDTH(3)) ifc ();

  assign ifa.en = en;  assign ifa.up_dn = up_dn;  assign ifa.clear = clear;
  assign ifa.load = load;  assign ifa.load_val = load_val;
  assign ifb.en = en;  assign ifb.up_dn = up_dn;  assign ifb.clear = clear;
  assign ifb.load = load;  assign ifb.load_val = load_val;
  assign ifc.en = en;  assign ifc.up_dn = up_dn;  assign ifc.clear = clear;
  assign ifc.load = load;  assign ifc.load_val = load_val[2:0];

  sync_updown_counter #(.WIDTH(4), .MOD_VAL(10), .PRESCALE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sync_updown_counter #(.WIDTH(4), .MOD_VAL(10), .PRESCALE(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  sync_updown_counter #(.WIDTH(3), .MOD_VAL(8),  .PRESCALE(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int mod_v[N] = '{10, 10, 8};
  int pre_v[N] = '{1, 3, 2};
  int mq[N];
  int mps[N];
  int mw[N];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i] = 0; mps[i] = 0; mw[i] = 0;
    end
  endtask

  // Reference: counting is modular arithmetic on 0..mod-1 (or clamped when saturating).
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      automatic int lv = (i == 2) ? int'(load_val[2:0]) : int'(load_val);
      automatic int boundary;
      if (clear) begin
        mq[i] = 0; mps[i] = 0; mw[i] = 0;
      end else if (load) begin
        mq[i] = (lv < mod_v[i]) ? lv : mod_v[i] - 1;
        mps[i] = 0; mw[i] = 0;
      end else if (!en) begin
        mw[i] = 0;
      end else begin
        mps[i] = (mps[i] + 1) % pre_v[i];
        mw[i]  = 0;
        if (mps[i] == 0) begin
          boundary = up_dn ? int'(mq[i] == mod_v[i] - 1) : int'(mq[i] == 0);
          mw[i] = boundary;
`ifdef SYNC_COUNTER_SAT_EN
          if (boundary == 0) mq[i] = mq[i] + (up_dn ? 1 : -1);
`else
          mq[i] = (mq[i] + (up_dn ? 1 : mod_v[i] - 1)) % mod_v[i];
`endif
        end
      end
    end
  endtask

  function automatic int model_tc(input int i);
    return up_dn ? int'(mq[i] == mod_v[i] - 1) : int'(mq[i] == 0);
  endfunction

  task automatic compare_all(input string ph);
    check({ph, " a.q"},    32'(ifa.q),    mq[0]);
    check({ph, " a.tc"},   32'(ifa.tc),   model_tc(0));
    check({ph, " a.wrap"}, 32'(ifa.wrap), mw[0]);
    check({ph, " b.q"},    32'(ifb.q),    mq[1]);
    check({ph, " b.tc"},   32'(ifb.tc),   model_tc(1));
    check({ph, " b.wrap"}, 32'(ifb.wrap), mw[1]);
    check({ph, " c.q"},    32'(ifc.q),    mq[2]);
    check({ph, " c.tc"},   32'(ifc.tc),   model_tc(2));
    check({ph, " c.wrap"}, 32'(ifc.wrap), mw[2]);
  endtask

  // Advance one edge, update the model with the inputs seen at that edge, sample 1ns later.
  task automatic tick(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(ph);
  endtask

  // Assert reset mid-cycle and check the outputs clear before any clock edge.
  task automatic async_reset(input string ph);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all(ph);
    check({ph, " a.q now"},    32'(ifa.q),    32'd0);
    check({ph, " a.wrap now"}, 32'(ifa.wrap), 32'd0);
    #1 rst = 1'b1;
  endtask

  task automatic set_in(input logic e, input logic ud, input logic c, input logic l, input logic [3:0] lv);
    en = e; up_dn = ud; clear = c; load = l; load_val = lv;
  endtask

`ifdef SYNC_COUNTER_SAT_EN
  int sat_q_up[4] = '{8, 9, 9, 9};
  int sat_w_up[4] = '{0, 0, 1, 1};
  int sat_q_dn[2] = '{0, 0};
  int sat_w_dn[2] = '{0, 1};
`endif

  initial begin
    rst = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    check("reset a.q", 32'(ifa.q), 32'd0);
    rst = 1'b1;

    // Modulo up count 0..9 then wrap
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 11; k++) begin
      tick("upwrap");
      if (k == 9) check("upwrap a.tc at 9", 32'(ifa.tc), 32'd1);
    end

    // Reset mid-count at q=9, then stays 0 with en=0
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    tick("load9");
    check("load9 a.q", 32'(ifa.q), 32'd9);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    async_reset("async");
    en = 1'b0;
    tick("post_reset");
    tick("post_reset");
    check("post_reset a.q", 32'(ifa.q), 32'd0);

    // Clamped load then count down through zero
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
    tick("clamp");
    check("clamp a.q", 32'(ifa.q), 32'd9);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (10) tick("down");

    // Priority: clear beats load beats step
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
    tick("load5");
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    tick("clear_prio");
    check("clear_prio a.q", 32'(ifa.q), 32'd0);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd6);
    tick("load_prio");
    check("load_prio a.q", 32'(ifa.q), 32'd6);

    // Prescaler period and stretch from en gaps
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick("ps_clear");
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    repeat (3) tick("ps_run");
    check("ps_run b.q after 3", 32'(ifb.q), 32'd1);
    repeat (4) tick("ps_run");
    en = 1'b0;
    repeat (2) tick("ps_gap");
    en = 1'b1;
    repeat (5) tick("ps_resume");
    up_dn = 1'b0;
    repeat (4) tick("ps_dirchg");

`ifdef SYNC_COUNTER_SAT_EN
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    tick("sat_load7");
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      tick("sat_up");
      check("sat_up a.q", 32'(ifa.q), 32'(sat_q_up[k]));
      check("sat_up a.wrap", 32'(ifa.wrap), 32'(sat_w_up[k]));
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    tick("sat_load1");
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 2; k++) begin
      tick("sat_dn");
      check("sat_dn a.q", 32'(ifa.q), 32'(sat_q_dn[k]));
      check("sat_dn a.wrap", 32'(ifa.wrap), 32'(sat_w_dn[k]));
    end
`endif

    // Randomised mix against the model
    for (int k = 0; k < 2000; k++) begin
      en       = ($urandom_range(3) != 0);
      clear    = ($urandom_range(15) == 0);
      load     = ($urandom_range(7) == 0);
      load_val = 4'($urandom);
      if ($urandom_range(7) == 0) up_dn = ~up_dn;
      tick("random");
      if ($urandom_range(63) == 0) async_reset("random_reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
